mux_scan_ctrl: RTL and testbench

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

---
 rtl/mux_scan_ctrl.sv | 107 ++++++++++
 tb/tb_mux_scan_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// Scan controller for a downstream 4x1 mux: steps the select lines 0..3, waits
// DWELL cycles on each, samples the mux output and reports the captured word.
module mux_scan_ctrl #(
  parameter int unsigned DWELL = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       f,
  output logic [1:0] s,
  output logic       busy,
  output logic       done,
  output logic [3:0] data_out
);

  // state  | meaning
  // IDLE   | waiting for start, s parked at 0
  // SETTLE | holding s for DWELL cycles, then sampling f into cap_q[s]
  // DONE   | one-cycle done pulse, data_out freshly loaded
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(DWELL - 1);

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [3:0] cap_q;
  logic [3:0] cap_d;
  logic [1:0] s_q;
  logic       busy_q;
  logic       done_q;
  logic [3:0] data_q;

  // Capture word including the bit sampled on this edge, so DONE can publish it.
  always_comb begin
    cap_d       = cap_q;
    cap_d[s_q]  = f;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      cap_q   <= 4'd0;
      s_q     <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          s_q    <= 2'd0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (start && !abort) begin
            state_q <= SETTLE;
            busy_q  <= 1'b1;
            cnt_q   <= 4'd0;
            cap_q   <= 4'd0;
          end
        end
        SETTLE: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            s_q     <= 2'd0;
            cnt_q   <= 4'd0;
          end else if (cnt_q == CNT_LAST) begin
            cap_q <= cap_d;
            cnt_q <= 4'd0;
            if (s_q == 2'd3) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              data_q  <= cap_d;
            end else begin
              s_q <= s_q + 2'd1;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          s_q     <= 2'd0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          s_q     <= 2'd0;
        end
      endcase
    end
  end

  assign s        = s_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = data_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: DWELL=1 and DWELL=3 instances, each driven
// by a behavioural 4x1 mux model (f = i[s]).
module tb_mux_scan_ctrl;

  logic       clk;
  logic       rst_n;

  logic       start1, abort1;
  logic [3:0] i1;
  logic       f1;
  logic [1:0] s1;
  logic       busy1, done1;
  logic [3:0] dout1;

  logic       start3, abort3;
  logic [3:0] i3;
  logic       f3;
  logic [1:0] s3;
  logic       busy3, done3;
  logic [3:0] dout3;

  int total;
  int passed;

  assign f1 = i1[s1];
  assign f3 = i3[s3];

  mux_scan_ctrl #(.DWELL(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .f(f1),
    .s(s1), .busy(busy1), .done(done1), .data_out(dout1)
  );

  mux_scan_ctrl #(.DWELL(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .f(f3),
    .s(s3), .busy(busy3), .done(done3), .data_out(dout3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one clock; inputs change and outputs are checked 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives a full DWELL=1 scan from IDLE and checks s/busy/done/data_out.
  task automatic scan1(input string tag, input logic [3:0] pat);
    i1     = pat;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_s"}, {6'd0, s1}, 8'(k));
      chk({tag, "_busy"}, {7'd0, busy1}, 8'd1);
      chk({tag, "_nodone"}, {7'd0, done1}, 8'd0);
      step();
    end
    chk({tag, "_done"}, {7'd0, done1}, 8'd1);
    chk({tag, "_busy_off"}, {7'd0, busy1}, 8'd0);
    chk({tag, "_s_done"}, {6'd0, s1}, 8'd3);
    chk({tag, "_data"}, {4'd0, dout1}, {4'd0, pat});
    step();
    chk({tag, "_done_pulse"}, {7'd0, done1}, 8'd0);
    chk({tag, "_s_idle"}, {6'd0, s1}, 8'd0);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    start1 = 1'b0; abort1 = 1'b0; i1 = 4'b0000;
    start3 = 1'b0; abort3 = 1'b0; i3 = 4'b0000;
    rst_n  = 1'b0;
    #12;
    chk("rst_s",    {6'd0, s1},    8'd0);
    chk("rst_busy", {7'd0, busy1}, 8'd0);
    chk("rst_done", {7'd0, done1}, 8'd0);
    chk("rst_data", {4'd0, dout1}, 8'd0);
    chk("rst_data3", {4'd0, dout3}, 8'd0);
    rst_n = 1'b1;
    step();

    // Basic DWELL=1 scan
    scan1("d1_1011", 4'b1011);
    step();
    chk("d1_idle_hold", {4'd0, dout1}, 8'b1011);

    // Abort while s==2: no done, data_out kept
    i1 = 4'b1110;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    step();
    step();
    chk("ab_s2", {6'd0, s1}, 8'd2);
    abort1 = 1'b1;
    step();
    abort1 = 1'b0;
    chk("ab_busy", {7'd0, busy1}, 8'd0);
    chk("ab_s",    {6'd0, s1},    8'd0);
    chk("ab_done", {7'd0, done1}, 8'd0);
    chk("ab_data", {4'd0, dout1}, 8'b1011);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("ab_quiet", {6'd0, done1, busy1}, 8'd0);
    end
    scan1("ab_0001", 4'b0001);

    // Abort and start together in IDLE: abort wins
    start1 = 1'b1;
    abort1 = 1'b1;
    step();
    chk("sa_idle", {7'd0, busy1}, 8'd0);
    start1 = 1'b0;
    abort1 = 1'b0;
    step();
    chk("sa_idle2", {7'd0, busy1}, 8'd0);

    // Start held high: back-to-back scans with one IDLE cycle between
    i1 = 4'b1101;
    start1 = 1'b1;
    step();
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < 4; k++) begin
        chk("bb_s", {6'd0, s1}, 8'(k));
        chk("bb_busy", {7'd0, busy1}, 8'd1);
        step();
      end
      chk("bb_done", {7'd0, done1}, 8'd1);
      chk("bb_data", {4'd0, dout1}, 8'b1101);
      step();
      chk("bb_idle", {6'd0, done1, busy1}, 8'd0);
      if (n == 2) start1 = 1'b0;
      step();
    end
    chk("bb_stop", {7'd0, busy1}, 8'd0);

    // Pattern changes right after s moves to 2
    i1 = 4'b0000;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    step();
    step();
    chk("mid_s2", {6'd0, s1}, 8'd2);
    i1 = 4'b1111;
    step();
    step();
    chk("mid_done", {7'd0, done1}, 8'd1);
    chk("mid_data", {4'd0, dout1}, 8'b1100);
    step();

    // DWELL=3: each select held 3 cycles, done in the 13th cycle
    i3 = 4'b0110;
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 3; j++) begin
        chk("d3_s", {6'd0, s3}, 8'(k));
        chk("d3_busy", {6'd0, done3, busy3}, 8'd1);
        step();
      end
    end
    chk("d3_done", {7'd0, done3}, 8'd1);
    chk("d3_data", {4'd0, dout3}, 8'b0110);
    step();
    chk("d3_pulse", {7'd0, done3}, 8'd0);

    // Asynchronous reset mid-scan while s==1
    i1 = 4'b0101;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    step();
    chk("ar_s1", {6'd0, s1}, 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_s",    {6'd0, s1},    8'd0);
    chk("ar_busy", {7'd0, busy1}, 8'd0);
    chk("ar_done", {7'd0, done1}, 8'd0);
    chk("ar_data", {4'd0, dout1}, 8'd0);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("ar_wait", {6'd0, done1, busy1}, 8'd0);
    end
    scan1("ar_1000", 4'b1000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
